serializer_sequencer: RTL and testbench

- Control block for the vector serializer that feeds the MAC datapath element by element.
- Accepts a programmed number of SIZE-element vectors from an upstream valid/ready producer and issues the serializer load strobe.
- Tracks element and vector indices for weight addressing, and flags first/last element of each vector.
- Upstream vector data is wired directly to the serializer; this block carries control only.

---
 rtl/serializer_sequencer.sv | 123 ++++++++++++
 tb/tb_serializer_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_sequencer.sv
// Control sequencer for the vector serializer: accepts a batch of SIZE-element vectors from a
// valid/ready producer, strobes the serializer load and tags each serial element with indices.
module serializer_sequencer #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned VEC_CNT_W = 16,
  localparam int unsigned IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [VEC_CNT_W-1:0] cfg_num_vectors,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 serializer_update,
  output logic                 out_valid,
  output logic                 out_first,
  output logic                 out_last,
  output logic [IDX_W-1:0]     elem_idx,
  output logic [VEC_CNT_W-1:0] vec_idx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StArmed, StShift, StDone} state_e;

  localparam logic [IDX_W-1:0] LastElem = IDX_W'(SIZE - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     elem_cnt_q;
  logic [VEC_CNT_W-1:0] vec_cnt_q;
  logic [VEC_CNT_W-1:0] num_vec_q;
  logic [VEC_CNT_W-1:0] vec_cnt_inc;
  logic                 elem_last;

  assign vec_cnt_inc = vec_cnt_q + VEC_CNT_W'(1);
  assign elem_last   = (elem_cnt_q == LastElem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      elem_cnt_q <= '0;
      vec_cnt_q  <= '0;
      num_vec_q  <= '0;
    end else if (abort) begin
      state_q    <= StIdle;
      elem_cnt_q <= '0;
      vec_cnt_q  <= '0;
      num_vec_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_num_vectors == '0) begin
              state_q <= StDone;
            end else begin
              num_vec_q <= cfg_num_vectors;
              vec_cnt_q <= '0;
              state_q   <= StArmed;
            end
          end
        end
        StArmed: begin
          // in_ready is high here, so in_valid alone marks the load handshake
          if (in_valid) begin
            if (SIZE == 1) begin
              vec_cnt_q <= vec_cnt_inc;
              if (vec_cnt_inc == num_vec_q) state_q <= StDone;
            end else begin
              elem_cnt_q <= IDX_W'(1);
              state_q    <= StShift;
            end
          end
        end
        StShift: begin
          if (elem_last) begin
            elem_cnt_q <= '0;
            vec_cnt_q  <= vec_cnt_inc;
            state_q    <= (vec_cnt_inc == num_vec_q) ? StDone : StArmed;
          end else begin
            elem_cnt_q <= elem_cnt_q + IDX_W'(1);
          end
        end
        StDone: begin
          vec_cnt_q <= '0;
          num_vec_q <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready          = (state_q == StArmed);
  assign serializer_update = in_valid & in_ready;
  assign busy              = (state_q != StIdle);
  assign done              = (state_q == StDone);

  always_comb begin
    out_valid = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    elem_idx  = '0;
    vec_idx   = '0;
    case (state_q)
      StArmed: begin
        // element 0 appears on serial_out in the same cycle as the load
        out_valid = in_valid;
        out_first = in_valid;
        out_last  = in_valid && (SIZE == 1);
        vec_idx   = vec_cnt_q;
      end
      StShift: begin
        out_valid = 1'b1;
        out_last  = elem_last;
        elem_idx  = elem_cnt_q;
        vec_idx   = vec_cnt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serializer_sequencer.sv
// Bench for serializer_sequencer: three sizes driven in parallel, checked each cycle against a
// batch-level model, plus directed literal expectations.
module tb_serializer_sequencer;

  localparam int unsigned VW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [VW-1:0] cfg_num_vectors = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;

  logic rdy_a, upd_a, ov_a, of_a, ol_a, busy_a, done_a;
  logic rdy_b, upd_b, ov_b, of_b, ol_b, busy_b, done_b;
  logic rdy_c, upd_c, ov_c, of_c, ol_c, busy_c, done_c;
  logic [1:0]    ei_a;
  logic [0:0]    ei_b;
  logic [2:0]    ei_c;
  logic [VW-1:0] vi_a, vi_b, vi_c;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  serializer_sequencer #(.SIZE(4), .VEC_CNT_W(VW)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_vectors(cfg_num_vectors), .abort(abort),
    .in_valid(in_valid), .in_ready(rdy_a), .serializer_update(upd_a), .out_valid(ov_a),
    .out_first(of_a), .out_last(ol_a), .elem_idx(ei_a), .vec_idx(vi_a), .busy(busy_a),
    .done(done_a)
  );
  serializer_sequencer #(.SIZE(1), .VEC_CNT_W(VW)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_vectors(cfg_num_vectors), .abort(abort),
    .in_valid(in_valid), .in_ready(rdy_b), .serializer_update(upd_b), .out_valid(ov_b),
    .out_first(of_b), .out_last(ol_b), .elem_idx(ei_b), .vec_idx(vi_b), .busy(busy_b),
    .done(done_b)
  );
  serializer_sequencer #(.SIZE(8), .VEC_CNT_W(VW)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_vectors(cfg_num_vectors), .abort(abort),
    .in_valid(in_valid), .in_ready(rdy_c), .serializer_update(upd_c), .out_valid(ov_c),
    .out_first(of_c), .out_last(ol_c), .elem_idx(ei_c), .vec_idx(vi_c), .busy(busy_c),
    .done(done_c)
  );

  // {0, ready, update, valid, first, last, busy, done, elem_idx[7:0], vec_idx[15:0]}
  logic [31:0] act_pk [3];
  assign act_pk[0] = {1'b0, rdy_a, upd_a, ov_a, of_a, ol_a, busy_a, done_a, 8'(ei_a), 16'(vi_a)};
  assign act_pk[1] = {1'b0, rdy_b, upd_b, ov_b, of_b, ol_b, busy_b, done_b, 8'(ei_b), 16'(vi_b)};
  assign act_pk[2] = {1'b0, rdy_c, upd_c, ov_c, of_c, ol_c, busy_c, done_c, 8'(ei_c), 16'(vi_c)};

  // Batch model: phase 0 idle, 1 running, 2 done; pos -1 = waiting for a load, else element shown
  typedef struct packed {
    int phase;
    int pos;
    int vec;
    int total;
  } mst_t;

  int   sz [3] = '{4, 1, 8};
  mst_t m  [3] = '{'{0, -1, 0, 0}, '{0, -1, 0, 0}, '{0, -1, 0, 0}};

  function automatic mst_t finish_vec(mst_t s);
    mst_t r = s;
    r.vec = r.vec + 1;
    r.pos = -1;
    if (r.vec == r.total) r.phase = 2;
    return r;
  endfunction

  function automatic mst_t model_next(int k);
    mst_t s = m[k];
    if (abort) begin
      s.phase = 0;
      s.pos   = -1;
      s.vec   = 0;
    end else begin
      case (s.phase)
        0: if (start) begin
          if (cfg_num_vectors == '0) begin
            s.phase = 2;
          end else begin
            s.phase = 1;
            s.total = int'(cfg_num_vectors);
            s.vec   = 0;
            s.pos   = -1;
          end
        end
        1: begin
          if (s.pos < 0) begin
            if (in_valid) begin
              if (sz[k] == 1) s = finish_vec(s);
              else s.pos = 1;
            end
          end else if (s.pos == sz[k] - 1) begin
            s = finish_vec(s);
          end else begin
            s.pos = s.pos + 1;
          end
        end
        default: begin
          s.phase = 0;
          s.vec   = 0;
        end
      endcase
    end
    return s;
  endfunction

  function automatic logic [31:0] model_out(int k);
    logic [31:0] r = '0;
    if (m[k].phase == 1) begin
      r[25] = 1'b1;
      r[15:0] = 16'(m[k].vec);
      if (m[k].pos < 0) begin
        r[30] = 1'b1;
        r[29] = in_valid;
        r[28] = in_valid;
        r[27] = in_valid;
        r[26] = in_valid && (sz[k] == 1);
      end else begin
        r[28] = 1'b1;
        r[26] = (m[k].pos == sz[k] - 1);
        r[23:16] = 8'(m[k].pos);
      end
    end else if (m[k].phase == 2) begin
      r[25] = 1'b1;
      r[24] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) m[k] <= '{0, -1, 0, 0};
    end else begin
      for (int k = 0; k < 3; k++) m[k] <= model_next(k);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_pk[k] !== model_out(k)) begin
          errors++;
          $display("FAIL cycle_cmp dut%0d t=%0t got %h want %h", k, $time, act_pk[k],
                   model_out(k));
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b1;
    while ((busy_a || busy_b || busy_c) && n < 300) begin
      step();
      n++;
    end
    chk("wait_idle_busy", int'(busy_a | busy_b | busy_c), 0);
  endtask

  initial begin
    // reset state
    step();
    step();
    for (int k = 0; k < 3; k++) chk("reset_outputs", int'(act_pk[k]), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    step();

    // SIZE=4, two vectors back to back
    start = 1'b1; cfg_num_vectors = 6'd2; in_valid = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("b2b_update", int'(upd_a), int'(t == 0 || t == 4));
      chk("b2b_elem_idx", int'(ei_a), (t < 8) ? t % 4 : 0);
      chk("b2b_last", int'(ol_a), int'(t == 3 || t == 7));
      chk("b2b_vec_idx", int'(vi_a), (t < 8) ? t / 4 : 0);
      chk("b2b_done", int'(done_a), int'(t == 8));
      chk("b2b_busy", int'(busy_a), int'(t < 9));
      step();
    end
    wait_idle();

    // SIZE=1, three vectors
    start = 1'b1; cfg_num_vectors = 6'd3; in_valid = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("s1_update", int'(upd_b), int'(t < 3));
      chk("s1_first", int'(of_b), int'(t < 3));
      chk("s1_last", int'(ol_b), int'(t < 3));
      chk("s1_vec_idx", int'(vi_b), (t < 3) ? t : 0);
      chk("s1_done", int'(done_b), int'(t == 3));
      step();
    end
    wait_idle();

    // SIZE=4, one vector with a delayed producer
    start = 1'b1; cfg_num_vectors = 6'd1; in_valid = 1'b0;
    step();
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("wait_ready", int'(rdy_a), 1);
      chk("wait_out_valid", int'(ov_a), 0);
      chk("wait_update", int'(upd_a), 0);
      step();
    end
    in_valid = 1'b1;
    @(negedge clk);
    chk("late_update", int'(upd_a), 1);
    chk("late_first", int'(of_a), 1);
    step();
    in_valid = 1'b0;
    for (int t = 1; t < 6; t++) begin
      @(negedge clk);
      chk("late_done", int'(done_a), int'(t == 4));
      step();
    end
    wait_idle();

    // zero-vector batch
    start = 1'b1; cfg_num_vectors = 6'd0; in_valid = 1'b0;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", int'(done_a), 1);
    chk("zero_busy", int'(busy_a), 1);
    chk("zero_update", int'(upd_a), 0);
    step();
    @(negedge clk);
    chk("zero_busy_after", int'(busy_a), 0);
    chk("zero_done_after", int'(done_a), 0);
    step();

    // SIZE=8 abort at element 3, then a clean rerun
    start = 1'b1; cfg_num_vectors = 6'd2; in_valid = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("pre_abort_elem", int'(ei_c), t);
      step();
    end
    abort = 1'b1;
    @(negedge clk);
    chk("abort_elem", int'(ei_c), 3);
    step();
    abort = 1'b0; in_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("abort_busy", int'(busy_c), 0);
      chk("abort_done", int'(done_c), 0);
      step();
    end
    start = 1'b1; cfg_num_vectors = 6'd1; in_valid = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("rerun_elem", int'(ei_c), (t < 8) ? t : 0);
      chk("rerun_last", int'(ol_c), int'(t == 7));
      chk("rerun_done", int'(done_c), int'(t == 8));
      step();
    end
    wait_idle();

    // asynchronous reset mid-shift
    start = 1'b1; cfg_num_vectors = 6'd3; in_valid = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("async_reset", int'(act_pk[k]), 0);
    step();
    rst_n = 1'b1;
    step();

    // start while busy is ignored
    start = 1'b1; cfg_num_vectors = 6'd2; in_valid = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("busy_start_done", int'(done_a), int'(t == 8));
      chk("busy_start_vec", int'(vi_a), (t < 8) ? t / 4 : 0);
      step();
      if (t == 1) begin
        start = 1'b1;
        cfg_num_vectors = 6'd5;
      end else begin
        start = 1'b0;
      end
    end
    wait_idle();

    // randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      start           = ($urandom_range(0, 5) == 0);
      cfg_num_vectors = 6'($urandom_range(0, 4));
      abort           = ($urandom_range(0, 59) == 0);
      in_valid        = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
